ad9122_spi_slave: RTL and testbench

- Synthesizable 3-wire SPI responder that emulates the AD9122 serial port: the device end of the link driven by the DAC SPI master.
- Oversamples SCLK/CSB/SDIO in the system clock domain, decodes the instruction byte, and services single-byte write or read transactions against an internal 8-bit register file.
- Used as the DAC stand-in for simulation and FPGA loopback, and to check the master's framing.

---
 rtl/ad9122_spi_pkg.sv | 36 +++
 rtl/ad9122_spi_slave_in_sync.sv | 36 +++
 rtl/ad9122_spi_slave.sv | 226 ++++++++++++++++++++++
 tb/tb_ad9122_spi_slave.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ad9122_spi_pkg.sv
// Shared definitions for the AD9122 serial-port responder: state encoding,
// frame geometry, instruction-byte layout and the AD9122 chip-ID value.
package ad9122_spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INSTR = 3'd1,
        WDATA = 3'd2,
        RDATA = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Bit counts are 5 bits wide to match bit_cnt directly.
    localparam logic [4:0] INSTR_BITS = 5'd8;
    localparam logic [4:0] DATA_BITS  = 5'd8;
    localparam logic [4:0] FRAME_BITS = INSTR_BITS + DATA_BITS;

    // Instruction byte: bit 7 is R/W (1 = read), bits 6:0 are the address.
    localparam int RW_BIT = 7;

    localparam logic [7:0] AD9122_CHIP_ID = 8'h08;

    // Complete FSM context, kept in one struct so checkers can bind to it.
    typedef struct packed {
        state_t     state;
        logic [4:0] bit_cnt;
        logic       rw;
        logic [6:0] addr;
    } fsm_t;

    // True when a 7-bit address maps onto an implemented register.
    function automatic logic addr_in_range(input logic [6:0] a, input int unsigned n);
        return 32'(a) < n;
    endfunction

endpackage

// File: rtl/ad9122_spi_slave_in_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, followed by a
// single-flop edge detector producing one-clk rise/fall pulses.
module spi_in_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // Shift the pin through the synchronizer chain and keep one delayed copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain[0] <= async_in;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[STAGES-1];
        end
    end

    assign sync_out = chain[STAGES-1];
    assign rise     = sync_out & ~prev;
    assign fall     = ~sync_out & prev;

endmodule

// File: rtl/ad9122_spi_slave.sv
// AD9122 3-wire serial-port responder. Oversamples SCLK/CSB/SDIO in the clk
// domain, decodes the instruction byte and services one-byte writes or reads
// against an internal register file.
//
// Write-commit interface: reg_wr_stb is a one-clk strobe with no back-pressure;
// reg_wr_addr/reg_wr_data change only in the cycle the strobe rises and hold
// until the next strobe, so a consumer may sample them on or after the strobe.
module ad9122_spi_slave
    import ad9122_spi_pkg::*;
#(
    parameter int unsigned NUM_REGS     = 32,
    parameter logic [6:0]  CHIP_ID_ADDR = 7'h1F,
    parameter logic [7:0]  CHIP_ID      = AD9122_CHIP_ID,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_csb,
    inout  wire        spi_sdio,
    output logic       reg_wr_stb,
    output logic [6:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic       xfer_abort,
    output logic       busy,
    input  logic [6:0] dbg_addr,
    output logic [7:0] dbg_data
);

    localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    // Synchronized pins and edge pulses
    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic csb_rise, csb_fall, csb_lvl_unused;
    logic sdio_s, sdio_rise_unused, sdio_fall_unused;

    // FSM and datapath state
    fsm_t       fsm_q, fsm_d;
    logic [7:0] shift_in, shift_in_d;
    logic [7:0] shift_out, shift_out_d;
    logic       sdio_oe, sdio_oe_d;
    logic       busy_d;
    logic       wr_commit;
    logic       abort_set;
    logic [7:0] shift_nxt;
    logic [7:0] rd_data;

    logic [7:0] regs [NUM_REGS];

    // SCLK idles low, CSB idles high; reset values match so no edge fires at release.
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk      (clk),
        .rst      (rst),
        .async_in (spi_sclk),
        .sync_out (sclk_lvl_unused),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csb (
        .clk      (clk),
        .rst      (rst),
        .async_in (spi_csb),
        .sync_out (csb_lvl_unused),
        .rise     (csb_rise),
        .fall     (csb_fall)
    );

    // SDIO goes through the same depth so a sample aligns with its SCLK edge.
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdio (
        .clk      (clk),
        .rst      (rst),
        .async_in (spi_sdio),
        .sync_out (sdio_s),
        .rise     (sdio_rise_unused),
        .fall     (sdio_fall_unused)
    );

    assign shift_nxt = {shift_in[6:0], sdio_s};

    // Value served to the master for the latched address.
    always_comb begin
        rd_data = 8'h00;
        if (fsm_q.addr == CHIP_ID_ADDR) begin
            rd_data = CHIP_ID;
        end else if (addr_in_range(fsm_q.addr, NUM_REGS)) begin
            rd_data = regs[fsm_q.addr[AW-1:0]];
        end
    end

    // Backdoor read port, same address decode as the serial read path.
    always_comb begin
        dbg_data = 8'h00;
        if (dbg_addr == CHIP_ID_ADDR) begin
            dbg_data = CHIP_ID;
        end else if (addr_in_range(dbg_addr, NUM_REGS)) begin
            dbg_data = regs[dbg_addr[AW-1:0]];
        end
    end

    // Next-state and datapath decode; a CSB rise overrides any same-cycle SCLK edge.
    always_comb begin
        fsm_d       = fsm_q;
        shift_in_d  = shift_in;
        shift_out_d = shift_out;
        sdio_oe_d   = sdio_oe;
        busy_d      = busy;
        wr_commit   = 1'b0;
        abort_set   = 1'b0;

        if (fsm_q.state != IDLE && csb_rise) begin
            fsm_d.state = IDLE;
            sdio_oe_d   = 1'b0;
            busy_d      = 1'b0;
            abort_set   = (fsm_q.bit_cnt < FRAME_BITS);
        end else begin
            case (fsm_q.state)
                IDLE: begin
                    if (csb_fall) begin
                        fsm_d.state   = INSTR;
                        fsm_d.bit_cnt = 5'd0;
                        busy_d        = 1'b1;
                    end
                end
                INSTR: begin
                    if (sclk_rise) begin
                        shift_in_d    = shift_nxt;
                        fsm_d.bit_cnt = fsm_q.bit_cnt + 5'd1;
                        if (fsm_q.bit_cnt == INSTR_BITS - 5'd1) begin
                            fsm_d.rw    = shift_nxt[RW_BIT];
                            fsm_d.addr  = shift_nxt[6:0];
                            fsm_d.state = shift_nxt[RW_BIT] ? RDATA : WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (sclk_rise) begin
                        shift_in_d    = shift_nxt;
                        fsm_d.bit_cnt = fsm_q.bit_cnt + 5'd1;
                        if (fsm_q.bit_cnt == FRAME_BITS - 5'd1) begin
                            wr_commit   = ~fsm_q.rw;
                            fsm_d.state = DONE;
                        end
                    end
                end
                RDATA: begin
                    if (sclk_rise) begin
                        fsm_d.bit_cnt = fsm_q.bit_cnt + 5'd1;
                        if (fsm_q.bit_cnt == FRAME_BITS - 5'd1) begin
                            sdio_oe_d   = 1'b0;
                            fsm_d.state = DONE;
                        end
                    end else if (sclk_fall) begin
                        // First fall after the instruction loads the byte and turns
                        // the pin around; later falls advance to the next bit.
                        if (!sdio_oe) begin
                            if (fsm_q.rw) begin
                                shift_out_d = rd_data;
                                sdio_oe_d   = 1'b1;
                            end
                        end else begin
                            shift_out_d = {shift_out[6:0], 1'b0};
                        end
                    end
                end
                DONE: begin
                    // Trailing master clocks are ignored until CSB rises.
                end
                default: begin
                    fsm_d.state = IDLE;
                    sdio_oe_d   = 1'b0;
                    busy_d      = 1'b0;
                end
            endcase
        end
    end

    // FSM state register and shift/turnaround state; reset drops oe asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q     <= '{state: IDLE, bit_cnt: 5'd0, rw: 1'b0, addr: 7'd0};
            shift_in  <= 8'h00;
            shift_out <= 8'h00;
            sdio_oe   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            shift_in  <= shift_in_d;
            shift_out <= shift_out_d;
            sdio_oe   <= sdio_oe_d;
            busy      <= busy_d;
        end
    end

    // Commit strobe, abort pulse and held write address/data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_wr_stb  <= 1'b0;
            xfer_abort  <= 1'b0;
            reg_wr_addr <= 7'd0;
            reg_wr_data <= 8'h00;
        end else begin
            reg_wr_stb <= wr_commit;
            xfer_abort <= abort_set;
            if (wr_commit) begin
                reg_wr_addr <= fsm_q.addr;
                reg_wr_data <= shift_nxt;
            end
        end
    end

    // Register file; the chip-ID slot and unimplemented addresses never take writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (wr_commit && addr_in_range(fsm_q.addr, NUM_REGS)
                     && fsm_q.addr != CHIP_ID_ADDR) begin
            regs[fsm_q.addr[AW-1:0]] <= shift_nxt;
        end
    end

    assign spi_sdio = sdio_oe ? shift_out[7] : 1'bz;

endmodule

// File: tb/tb_ad9122_spi_slave.sv
// Directed bench for ad9122_spi_slave: a bit-banged 3-wire master at clk/10,
// a register model with hand-set expectations and a read-data queue.
module tb_ad9122_spi_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_sclk;
    logic       spi_csb;
    wire        spi_sdio;
    logic       reg_wr_stb;
    logic [6:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       xfer_abort;
    logic       busy;
    logic [6:0] dbg_addr;
    logic [7:0] dbg_data;

    logic m_oe;
    logic m_bit;

    int n_cmp = 0;
    int n_err = 0;
    int stb_cnt = 0;
    int abort_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_regs[32];

    assign spi_sdio = m_oe ? m_bit : 1'bz;

    ad9122_spi_slave dut (
        .clk         (clk),
        .rst         (rst),
        .spi_sclk    (spi_sclk),
        .spi_csb     (spi_csb),
        .spi_sdio    (spi_sdio),
        .reg_wr_stb  (reg_wr_stb),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .xfer_abort  (xfer_abort),
        .busy        (busy),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Clock
    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (reg_wr_stb) stb_cnt++;
        if (xfer_abort) abort_cnt++;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_dbg(input logic [6:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1;
        check($sformatf("dbg_data[0x%0h]", a), dbg_data, exp);
    endtask

    // One SPI frame: n_rise SCLK rises, then (unless keep_csb) two trailing
    // clocks for full frames and CSB release.
    task automatic spi_frame(input logic [7:0] instr, input logic [7:0] wdata,
                             input int n_rise, input bit keep_csb,
                             output logic [7:0] rdata);
        bit is_rd;
        is_rd = instr[7];
        rdata = 8'h00;
        spi_csb = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_in_frame", busy, 1);
        for (int i = 0; i < n_rise; i++) begin
            spi_sclk = 1'b0;
            if (i < 8) begin
                m_oe = 1'b1;
                m_bit = instr[7-i];
            end else if (!is_rd) begin
                m_oe = 1'b1;
                m_bit = wdata[15-i];
            end else begin
                m_oe = 1'b0;
            end
            repeat (5) @(negedge clk);
            check($sformatf("sdio_oe_bit%0d", i), dut.sdio_oe, (is_rd && i >= 8));
            if (is_rd && i >= 8) rdata[15-i] = spi_sdio;
            spi_sclk = 1'b1;
            repeat (5) @(negedge clk);
        end
        if (keep_csb) return;
        m_oe = 1'b0;
        if (n_rise == 16) begin
            for (int j = 0; j < 2; j++) begin
                spi_sclk = 1'b0;
                repeat (5) @(negedge clk);
                check("sdio_oe_trailing", dut.sdio_oe, 0);
                spi_sclk = 1'b1;
                repeat (5) @(negedge clk);
            end
        end
        spi_sclk = 1'b0;
        repeat (5) @(negedge clk);
        spi_csb = 1'b1;
        repeat (10) @(negedge clk);
        check("busy_after_frame", busy, 0);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) exp_regs[k] = 8'h00;
        exp_regs[31] = 8'h08;
    endtask

    initial begin
        logic [7:0] rd;
        int s0;
        int a0;

        // Reset
        rst = 1'b1;
        spi_sclk = 1'b0;
        spi_csb = 1'b1;
        m_oe = 1'b0;
        m_bit = 1'b0;
        dbg_addr = 7'd0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_busy", busy, 0);
        check("rst_wr_stb", reg_wr_stb, 0);
        check("rst_abort", xfer_abort, 0);
        check("rst_wr_addr", reg_wr_addr, 0);
        check("rst_wr_data", reg_wr_data, 0);
        check("rst_sdio_oe", dut.sdio_oe, 0);
        check_dbg(7'h05, 8'h00);
        check_dbg(7'h1F, 8'h08);
        check_dbg(7'h40, 8'h00);

        // Write 0x05 = 0xA5
        s0 = stb_cnt;
        spi_frame(8'h05, 8'hA5, 16, 1'b0, rd);
        exp_regs[5] = 8'hA5;
        check("wr05_stb_count", 16'(stb_cnt - s0), 1);
        check("wr05_addr", reg_wr_addr, 7'h05);
        check("wr05_data", reg_wr_data, 8'hA5);
        check_dbg(7'h05, exp_regs[5]);

        // Read chip ID, attempt to overwrite it, read again
        exp_q.push_back(8'h08);
        spi_frame(8'h9F, 8'h00, 16, 1'b0, rd);
        check("rd_chip_id", rd, exp_q.pop_front());

        s0 = stb_cnt;
        spi_frame(8'h1F, 8'h55, 16, 1'b0, rd);
        check("wr1f_stb_count", 16'(stb_cnt - s0), 1);
        check("wr1f_addr", reg_wr_addr, 7'h1F);
        check("wr1f_data", reg_wr_data, 8'h55);

        exp_q.push_back(8'h08);
        spi_frame(8'h9F, 8'h00, 16, 1'b0, rd);
        check("rd_chip_id_again", rd, exp_q.pop_front());
        check_dbg(7'h1F, 8'h08);

        // Write 0x03 = 0x3C, read it back
        spi_frame(8'h03, 8'h3C, 16, 1'b0, rd);
        exp_regs[3] = 8'h3C;
        exp_q.push_back(8'h3C);
        spi_frame(8'h83, 8'h00, 16, 1'b0, rd);
        check("rd03", rd, exp_q.pop_front());

        // Out-of-range write is dropped but still strobes
        s0 = stb_cnt;
        spi_frame(8'h40, 8'h77, 16, 1'b0, rd);
        check("wr40_stb_count", 16'(stb_cnt - s0), 1);
        check("wr40_addr", reg_wr_addr, 7'h40);
        check("wr40_data", reg_wr_data, 8'h77);
        exp_q.push_back(8'h00);
        spi_frame(8'hC0, 8'h00, 16, 1'b0, rd);
        check("rd40", rd, exp_q.pop_front());
        for (int a = 0; a < 32; a++) check_dbg(7'(a), exp_regs[a]);

        // Aborted write after 11 SCLKs, then a full write
        s0 = stb_cnt;
        a0 = abort_cnt;
        spi_frame(8'h07, 8'hFF, 11, 1'b0, rd);
        check("abort_count", 16'(abort_cnt - a0), 1);
        check("abort_no_stb", 16'(stb_cnt - s0), 0);
        check_dbg(7'h07, 8'h00);
        spi_frame(8'h07, 8'h12, 16, 1'b0, rd);
        exp_regs[7] = 8'h12;
        check("wr07_stb_count", 16'(stb_cnt - s0), 1);
        check("wr07_no_new_abort", 16'(abort_cnt - a0), 1);
        check("wr07_data", reg_wr_data, 8'h12);
        check_dbg(7'h07, exp_regs[7]);

        // Reset in the middle of a read data phase
        spi_frame(8'h83, 8'h00, 12, 1'b1, rd);
        spi_sclk = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_read_oe", dut.sdio_oe, 1);
        check("mid_read_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_oe", dut.sdio_oe, 0);
        check("async_rst_busy", busy, 0);
        spi_csb = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        check("post_rst_wr_addr", reg_wr_addr, 0);
        check("post_rst_wr_data", reg_wr_data, 0);
        check_dbg(7'h03, exp_regs[3]);
        check_dbg(7'h05, exp_regs[5]);
        check_dbg(7'h07, exp_regs[7]);
        exp_q.push_back(8'h00);
        spi_frame(8'h85, 8'h00, 16, 1'b0, rd);
        check("rd05_after_rst", rd, exp_q.pop_front());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
